// File: rtl/imm_gen_pkg.sv
// Shared format codes, opcode constants and helpers for the immediate generator.
// The optional CSR zimm decode is enabled by defining IMM_GEN_CSR_ZIMM_EN.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FmtR    = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtZ    = 3'd6,
        FmtNone = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational RISC-V immediate decoder: format, sign-extended immediate, illegal flag.
// With IMM_GEN_CSR_ZIMM_EN defined, CSR immediate forms decode as fmt Z.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32     = '0;
        fmt_o     = FmtNone;
        illegal_o = 1'b0;
        unique case (instr_i[6:0])
            OpcLoad, OpcOpImm, OpcJalr: begin
                fmt_o = FmtI;
                imm32 = sext12(instr_i[31:20]);
            end
            OpcStore: begin
                fmt_o = FmtS;
                imm32 = sext12({instr_i[31:25], instr_i[11:7]});
            end
            OpcBranch: begin
                fmt_o = FmtB;
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            OpcLui, OpcAuipc: begin
                fmt_o = FmtU;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OpcJal: begin
                fmt_o = FmtJ;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            OpcOp: begin
                fmt_o = FmtR;
            end
            OpcSystem: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
                // funct3[2] selects the csrr*i forms whose rs1 field is a 5-bit zimm
                if (instr_i[14]) begin
                    fmt_o = FmtZ;
                    imm32 = {27'b0, instr_i[19:15]};
                end else begin
                    fmt_o = FmtI;
                    imm32 = sext12(instr_i[31:20]);
                end
`else
                fmt_o = FmtI;
                imm32 = sext12(instr_i[31:20]);
`endif
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry (output + skid) valid/ready buffer.
// Optional CSR zimm decode via IMM_GEN_CSR_ZIMM_EN (handled in imm_gen_decode).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
    } entry_t;

    localparam entry_t EntryReset = '{instr: '0, imm: '0, fmt: FmtNone, illegal: 1'b0};

    entry_t   dec_entry;
    entry_t   out_q, out_d, skid_q, skid_d;
    logic     out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic     accept, xfer;

    imm_gen_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_entry.imm),
        .fmt_o     (dec_entry.fmt),
        .illegal_o (dec_entry.illegal)
    );

    assign dec_entry.instr = in_instr;

    assign accept = in_valid && !skid_valid_q;
    assign xfer   = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (xfer || !out_valid_q) begin
            // Output slot frees up: the skid entry is older, so it goes first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= EntryReset;
            skid_q       <= EntryReset;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;

endmodule
